// File: rtl/seq_add.sv
// seq_add: multi-cycle add/subtract over B-bit operands, processed W bits
// per clock (LSB chunk first) with the ripple carry held in a register.
// The result, carry and signed overflow are published together with a
// one-cycle done pulse; partial sums stay internal until completion.
module seq_add #(
   parameter int B = 8,
   parameter int W = 2
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic         sub,
   input  logic [B-1:0] a,
   input  logic [B-1:0] b,
   input  logic         ca,
   output logic         busy,
   output logic         done,
   output logic [B-1:0] su,
   output logic         co,
   output logic         ov
);

   localparam int N  = B / W;
   localparam int CW = (N > 1) ? $clog2(N) : 1;
   localparam int IW = $clog2(B);

   typedef enum logic {IDLE, RUN} state_t;

   state_t         state;
   state_t         state_nx;
   logic [CW-1:0]  cnt;
   logic [B-1:0]   a_r;
   logic [B-1:0]   b_r;
   logic [B-1:0]   res_r;
   logic [B-1:0]   res_nx;
   logic           carry_r;
   logic [IW-1:0]  base;
   logic [W-1:0]   a_ch;
   logic [W-1:0]   b_ch;
   logic [W-1:0]   s_ch;
   logic           c_out;
   logic           last;
   logic           accept;

   // Signed overflow of the MSB: the carry into the MSB is recovered from
   // the MSB operand and sum bits, then compared with the carry out.
   function automatic logic signed_ovf(input logic a_msb, input logic b_msb,
                                       input logic s_msb, input logic c_msb_out);
      return (a_msb ^ b_msb ^ s_msb) ^ c_msb_out;
   endfunction

   assign accept = (state == IDLE) && start;
   assign busy   = (state == RUN);
   assign last   = (cnt == CW'(N - 1));
   assign base   = IW'(cnt) * IW'(W);
   assign a_ch   = a_r[base +: W];
   assign b_ch   = b_r[base +: W];

   // Chunk adder: W-bit slice of both operands plus the stored carry.
   always_comb begin
      {c_out, s_ch} = {1'b0, a_ch} + {1'b0, b_ch} + {{W{1'b0}}, carry_r};
   end

   // Merge the fresh chunk sum into the partial result at the current slice.
   always_comb begin
      res_nx = res_r;
      res_nx[base +: W] = s_ch;
   end

   // Next-state logic: IDLE waits for start, RUN leaves after the last chunk.
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (start) state_nx = RUN;
         RUN:     if (last)  state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   // Operand capture and per-chunk ripple. Subtraction is a + ~b + ~ca, so
   // the inversions are applied once at capture time.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_r     <= '0;
         b_r     <= '0;
         res_r   <= '0;
         carry_r <= 1'b0;
         cnt     <= '0;
      end else if (accept) begin
         a_r     <= a;
         b_r     <= sub ? ~b : b;
         carry_r <= sub ? ~ca : ca;
         res_r   <= '0;
         cnt     <= '0;
      end else if (state == RUN) begin
         res_r   <= res_nx;
         carry_r <= c_out;
         cnt     <= last ? '0 : cnt + 1'b1;
      end
   end

   // Publish result, carry and overflow together with the done pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         su   <= '0;
         co   <= 1'b0;
         ov   <= 1'b0;
         done <= 1'b0;
      end else begin
         done <= 1'b0;
         if ((state == RUN) && last) begin
            su   <= res_nx;
            co   <= c_out;
            ov   <= signed_ovf(a_ch[W-1], b_ch[W-1], s_ch[W-1], c_out);
            done <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_seq_add.sv
// Bench for seq_add: three instances (W = 2, 1, 8 with B = 8) checked
// against fixed vectors, an arithmetic reference model and handshake cases.
module tb_seq_add;

   logic       clk;
   logic       rst_n;
   logic       sub;
   logic [7:0] a;
   logic [7:0] b;
   logic       ca;
   logic       start_v [3];
   logic       busy_v  [3];
   logic       done_v  [3];
   logic [7:0] su_v    [3];
   logic       co_v    [3];
   logic       ov_v    [3];

   int n_vec;
   int n_err;

   typedef struct {
      logic       s;
      logic [7:0] av;
      logic [7:0] bv;
      logic       c;
      logic [7:0] esu;
      logic       eco;
      logic       eov;
   } vec_t;

   vec_t tbl [6];

   for (genvar g = 0; g < 3; g++) begin : g_dut
      seq_add #(.B(8), .W(g == 0 ? 2 : (g == 1 ? 1 : 8))) u_dut (
         .clk  (clk),
         .rst_n(rst_n),
         .start(start_v[g]),
         .sub  (sub),
         .a    (a),
         .b    (b),
         .ca   (ca),
         .busy (busy_v[g]),
         .done (done_v[g]),
         .su   (su_v[g]),
         .co   (co_v[g]),
         .ov   (ov_v[g])
      );
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int wv(input int g);
      return (g == 0) ? 2 : ((g == 1) ? 1 : 8);
   endfunction

   function automatic int nch(input int g);
      return 8 / wv(g);
   endfunction

   // Reference: plain integer arithmetic on unsigned and signed views.
   function automatic void model(input logic s, input logic [7:0] av, input logic [7:0] bv,
                                 input logic c, output logic [7:0] esu,
                                 output logic eco, output logic eov);
      int ua, ub, sa, sb, ci, r, rs;
      ua = int'(av);
      ub = int'(bv);
      sa = int'($signed(av));
      sb = int'($signed(bv));
      ci = c ? 1 : 0;
      if (s) begin
         r   = ua - ub - ci;
         rs  = sa - sb - ci;
         eco = (r >= 0);
      end else begin
         r   = ua + ub + ci;
         rs  = sa + sb + ci;
         eco = (r > 255);
      end
      esu = r[7:0];
      eov = (rs > 127) || (rs < -128);
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic run_op(input int g, input logic s, input logic [7:0] av, input logic [7:0] bv,
                         input logic c, input logic [7:0] esu, input logic eco,
                         input logic eov, input string tag);
      int   lat;
      logic bok;
      string t;
      t = $sformatf("%s[W=%0d]", tag, wv(g));
      @(negedge clk);
      sub = s; a = av; b = bv; ca = c; start_v[g] = 1'b1;
      @(posedge clk); #1;
      start_v[g] = 1'b0;
      bok = busy_v[g];
      lat = 0;
      for (int k = 1; k <= 40; k++) begin
         @(posedge clk); #1;
         if (done_v[g]) begin
            lat = k;
            if (busy_v[g]) bok = 1'b0;
            break;
         end
         if (!busy_v[g]) bok = 1'b0;
      end
      check({t, " latency"}, lat, nch(g));
      check({t, " busy"}, bok, 1);
      check({t, " su"}, su_v[g], esu);
      check({t, " co"}, co_v[g], eco);
      check({t, " ov"}, ov_v[g], eov);
      @(posedge clk); #1;
      check({t, " done width"}, done_v[g], 0);
   endtask

   task automatic run_rand(input int g);
      logic       s, c, eco, eov;
      logic [7:0] av, bv, esu;
      s  = 1'($urandom_range(0, 1));
      c  = 1'($urandom_range(0, 1));
      av = 8'($urandom_range(0, 255));
      bv = 8'($urandom_range(0, 255));
      model(s, av, bv, c, esu, eco, eov);
      run_op(g, s, av, bv, c, esu, eco, eov, "rand");
   endtask

   // start re-pulsed with new operands while busy must not disturb the result.
   task automatic busy_ignore(input int g);
      int   lat;
      logic extra;
      string t;
      t = $sformatf("ignore[W=%0d]", wv(g));
      @(negedge clk);
      sub = 1'b0; a = 8'h0F; b = 8'hCC; ca = 1'b0; start_v[g] = 1'b1;
      @(posedge clk); #1;
      start_v[g] = 1'b0;
      @(negedge clk);
      start_v[g] = 1'b1; a = 8'h55; b = 8'h11; ca = 1'b1; sub = 1'b1;
      lat = 0;
      for (int k = 1; k <= 40; k++) begin
         @(posedge clk); #1;
         if (k == 1) start_v[g] = 1'b0;
         if (done_v[g]) begin
            lat = k;
            break;
         end
      end
      check({t, " latency"}, lat, nch(g));
      check({t, " su"}, su_v[g], 8'hDB);
      check({t, " co"}, co_v[g], 0);
      extra = 1'b0;
      for (int k = 0; k < 2 * nch(g) + 2; k++) begin
         @(posedge clk); #1;
         if (busy_v[g] || done_v[g]) extra = 1'b1;
      end
      check({t, " no restart"}, extra, 0);
   endtask

   // start held high through the done cycle launches a second operation.
   task automatic back_to_back(input int g);
      int gap;
      string t;
      t = $sformatf("b2b[W=%0d]", wv(g));
      @(negedge clk);
      sub = 1'b0; a = 8'h6A; b = 8'hD5; ca = 1'b0; start_v[g] = 1'b1;
      @(posedge clk); #1;
      for (int k = 1; k <= 40; k++) begin
         @(posedge clk); #1;
         if (done_v[g]) break;
      end
      check({t, " first su"}, su_v[g], 8'h3F);
      gap = 0;
      for (int k = 1; k <= 40; k++) begin
         @(posedge clk); #1;
         if (k == 1) start_v[g] = 1'b0;
         if (done_v[g]) begin
            gap = k;
            break;
         end
      end
      start_v[g] = 1'b0;
      check({t, " gap"}, gap, nch(g) + 1);
      check({t, " second su"}, su_v[g], 8'h3F);
      check({t, " second co"}, co_v[g], 1);
   endtask

   // Asynchronous reset in the middle of RUN clears everything immediately.
   task automatic mid_reset(input int g);
      logic seen;
      string t;
      t = $sformatf("reset[W=%0d]", wv(g));
      run_op(g, 1'b0, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, "pre-reset");
      @(negedge clk);
      sub = 1'b0; a = 8'h0F; b = 8'hCC; ca = 1'b0; start_v[g] = 1'b1;
      @(posedge clk); #1;
      start_v[g] = 1'b0;
      if (nch(g) > 2) begin
         repeat (2) @(posedge clk);
      end
      #2;
      rst_n = 1'b0;
      #1;
      check({t, " busy"}, busy_v[g], 0);
      check({t, " done"}, done_v[g], 0);
      check({t, " su"}, su_v[g], 0);
      check({t, " co"}, co_v[g], 0);
      check({t, " ov"}, ov_v[g], 0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      seen = 1'b0;
      for (int k = 0; k < 2 * nch(g) + 2; k++) begin
         @(posedge clk); #1;
         if (done_v[g] || busy_v[g] || (su_v[g] != 8'h00)) seen = 1'b1;
      end
      check({t, " aborted"}, seen, 0);
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;
      rst_n = 1'b0;
      sub = 1'b0; a = 8'h00; b = 8'h00; ca = 1'b0;
      for (int g = 0; g < 3; g++) start_v[g] = 1'b0;

      tbl[0] = '{1'b0, 8'h0F, 8'hCC, 1'b0, 8'hDB, 1'b0, 1'b0};
      tbl[1] = '{1'b0, 8'h6A, 8'hD5, 1'b0, 8'h3F, 1'b1, 1'b0};
      tbl[2] = '{1'b0, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
      tbl[3] = '{1'b0, 8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0};
      tbl[4] = '{1'b1, 8'h05, 8'h07, 1'b0, 8'hFE, 1'b0, 1'b0};
      tbl[5] = '{1'b1, 8'h80, 8'h01, 1'b0, 8'h7F, 1'b1, 1'b1};

      #1;
      for (int g = 0; g < 3; g++) begin
         check($sformatf("reset busy[W=%0d]", wv(g)), busy_v[g], 0);
         check($sformatf("reset done[W=%0d]", wv(g)), done_v[g], 0);
         check($sformatf("reset su[W=%0d]", wv(g)), su_v[g], 0);
         check($sformatf("reset co[W=%0d]", wv(g)), co_v[g], 0);
         check($sformatf("reset ov[W=%0d]", wv(g)), ov_v[g], 0);
      end
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      for (int g = 0; g < 3; g++) begin
         for (int i = 0; i < 6; i++) begin
            run_op(g, tbl[i].s, tbl[i].av, tbl[i].bv, tbl[i].c,
                   tbl[i].esu, tbl[i].eco, tbl[i].eov, $sformatf("vec%0d", i));
         end
         busy_ignore(g);
         back_to_back(g);
         mid_reset(g);
         for (int i = 0; i < 25; i++) run_rand(g);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

endmodule
